// File: rtl/mipi_csi_rx_raw_line_sequencer.sv
// Per-packet sequencer in front of the 4-lane RAW depacker: gates payload words,
// enforces the inter-packet valid-low gap, and tracks line/frame boundaries and errors.
module mipi_csi_rx_raw_line_sequencer #(
    parameter int GAP_CYCLES    = 2,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        header_valid_i,
    input  logic [5:0]  header_dt_i,
    input  logic [15:0] header_wc_i,
    input  logic        payload_valid_i,
    input  logic [63:0] payload_i,
    input  logic [15:0] expected_pixels_i,
    output logic        depack_valid_o,
    output logic [63:0] depack_data_o,
    output logic [2:0]  depack_type_o,
    input  logic        depack_out_valid_i,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_start_o,
    output logic        line_end_o,
    output logic [15:0] line_count_o,
    output logic [15:0] pixel_count_o,
    output logic        busy_o,
    output logic        err_unsupported_o,
    output logic        err_short_o,
    output logic        err_long_o,
    output logic        err_gap_o,
    output logic        err_overrun_o
);

    // state   | meaning
    // IDLE    | waiting for a header; only state where depack_type_o may change
    // PAYLOAD | forwarding ceil(wc/8) words to the depacker
    // FLUSH   | valid low, waiting for depacker output to drain (or timeout)
    // GAP     | valid held low so the depacker can rewind
    // DISCARD | swallowing payload of an unsupported long packet
    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_FLUSH, S_GAP, S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] words_q, words_d;
    logic [15:0] tmr_q, tmr_d;
    logic        seen_q, seen_d;
    logic [15:0] pix_q, pix_d;

    logic        valid_d, fs_d, fe_d, ls_d, le_d;
    logic        unsup_d, short_d, long_d, gap_d, ovr_d;
    logic [63:0] data_d;
    logic [2:0]  type_d;
    logic [15:0] line_cnt_d, pix_out_d;
    logic [16:0] wc_sum;
    logic [13:0] wc_words;
    logic        is_raw, flush_exit;

    assign wc_sum   = {1'b0, header_wc_i} + 17'd7;
    assign wc_words = wc_sum[16:3];
    assign is_raw   = (header_dt_i == 6'h2B) || (header_dt_i == 6'h2C) || (header_dt_i == 6'h2D);
    assign busy_o   = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        tmr_d      = tmr_q;
        seen_d     = seen_q;
        pix_d      = pix_q;
        valid_d    = 1'b0;
        data_d     = depack_data_o;
        type_d     = depack_type_o;
        fs_d       = 1'b0;
        fe_d       = 1'b0;
        ls_d       = 1'b0;
        le_d       = 1'b0;
        unsup_d    = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        gap_d      = 1'b0;
        ovr_d      = header_valid_i && (state_q != S_IDLE);
        line_cnt_d = line_count_o;
        pix_out_d  = pixel_count_o;
        flush_exit = 1'b0;

        if ((state_q == S_PAYLOAD || state_q == S_FLUSH) && depack_out_valid_i)
            pix_d = (pix_q > 16'hFFF7) ? 16'hFFFF : pix_q + 16'd8;

        case (state_q)
            S_IDLE: begin
                if (header_valid_i) begin
                    if (header_dt_i == 6'h00) begin
                        fs_d       = 1'b1;
                        line_cnt_d = 16'd0;
                    end else if (header_dt_i == 6'h01) begin
                        fe_d = 1'b1;
                    end else if (is_raw) begin
                        if (header_wc_i != 16'd0) begin
                            type_d  = header_dt_i[2:0];
                            words_d = wc_words;
                            ls_d    = 1'b1;
                            pix_d   = 16'd0;
                            state_d = S_PAYLOAD;
                        end
                    end else if (header_dt_i >= 6'h10) begin
                        unsup_d = 1'b1;
                        words_d = wc_words;
                        state_d = S_DISCARD;
                    end
                end
            end
            S_PAYLOAD: begin
                seen_d = 1'b0;
                tmr_d  = 16'(FLUSH_TIMEOUT - 1);
                if (payload_valid_i) begin
                    valid_d = 1'b1;
                    data_d  = payload_i;
                    words_d = words_q - 14'd1;
                    if (words_q == 14'd1)
                        state_d = S_FLUSH;
                end else begin
                    gap_d   = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (depack_out_valid_i)
                    seen_d = 1'b1;
                flush_exit = (seen_q && !depack_out_valid_i) || (tmr_q == 16'd0);
                if (flush_exit) begin
                    le_d       = 1'b1;
                    pix_out_d  = pix_q;
                    line_cnt_d = (line_count_o == 16'hFFFF) ? 16'hFFFF : line_count_o + 16'd1;
                    if (expected_pixels_i != 16'd0) begin
                        short_d = (pix_q < expected_pixels_i);
                        long_d  = (pix_q > expected_pixels_i);
                    end
                    tmr_d   = 16'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_GAP: begin
                if (tmr_q == 16'd0)
                    state_d = S_IDLE;
                else
                    tmr_d = tmr_q - 16'd1;
            end
            S_DISCARD: begin
                // a payload gap simply ends the discard early
                if (words_q == 14'd0 || !payload_valid_i) begin
                    tmr_d   = 16'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else begin
                    words_d = words_q - 14'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= S_IDLE;
            words_q           <= '0;
            tmr_q             <= '0;
            seen_q            <= 1'b0;
            pix_q             <= '0;
            depack_valid_o    <= 1'b0;
            depack_data_o     <= '0;
            depack_type_o     <= '0;
            frame_start_o     <= 1'b0;
            frame_end_o       <= 1'b0;
            line_start_o      <= 1'b0;
            line_end_o        <= 1'b0;
            line_count_o      <= '0;
            pixel_count_o     <= '0;
            err_unsupported_o <= 1'b0;
            err_short_o       <= 1'b0;
            err_long_o        <= 1'b0;
            err_gap_o         <= 1'b0;
            err_overrun_o     <= 1'b0;
        end else begin
            state_q           <= state_d;
            words_q           <= words_d;
            tmr_q             <= tmr_d;
            seen_q            <= seen_d;
            pix_q             <= pix_d;
            depack_valid_o    <= valid_d;
            depack_data_o     <= data_d;
            depack_type_o     <= type_d;
            frame_start_o     <= fs_d;
            frame_end_o       <= fe_d;
            line_start_o      <= ls_d;
            line_end_o        <= le_d;
            line_count_o      <= line_cnt_d;
            pixel_count_o     <= pix_out_d;
            err_unsupported_o <= unsup_d;
            err_short_o       <= short_d;
            err_long_o        <= long_d;
            err_gap_o         <= gap_d;
            err_overrun_o     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_raw_line_sequencer.sv
// Directed bench for the RAW line sequencer; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_mipi_csi_rx_raw_line_sequencer;

    localparam int GAP = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        header_valid_i;
    logic [5:0]  header_dt_i;
    logic [15:0] header_wc_i;
    logic        payload_valid_i;
    logic [63:0] payload_i;
    logic [15:0] expected_pixels_i;
    logic        depack_valid_o;
    logic [63:0] depack_data_o;
    logic [2:0]  depack_type_o;
    logic        depack_out_valid_i;
    logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
    logic [15:0] line_count_o, pixel_count_o;
    logic        busy_o;
    logic        err_unsupported_o, err_short_o, err_long_o, err_gap_o, err_overrun_o;

    int errors = 0;
    int checks = 0;

    int n_valid = 0, n_ls = 0, n_le = 0, n_unsup = 0, low_run = 0;

    mipi_csi_rx_raw_line_sequencer #(.GAP_CYCLES(GAP), .FLUSH_TIMEOUT(15)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .header_valid_i(header_valid_i), .header_dt_i(header_dt_i), .header_wc_i(header_wc_i),
        .payload_valid_i(payload_valid_i), .payload_i(payload_i),
        .expected_pixels_i(expected_pixels_i),
        .depack_valid_o(depack_valid_o), .depack_data_o(depack_data_o), .depack_type_o(depack_type_o),
        .depack_out_valid_i(depack_out_valid_i),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .line_start_o(line_start_o), .line_end_o(line_end_o),
        .line_count_o(line_count_o), .pixel_count_o(pixel_count_o), .busy_o(busy_o),
        .err_unsupported_o(err_unsupported_o), .err_short_o(err_short_o), .err_long_o(err_long_o),
        .err_gap_o(err_gap_o), .err_overrun_o(err_overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (depack_valid_o) begin
            n_valid = n_valid + 1;
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
        if (line_start_o) n_ls = n_ls + 1;
        if (line_end_o) n_le = n_le + 1;
        if (err_unsupported_o) n_unsup = n_unsup + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        header_valid_i     = 1'b0;
        header_dt_i        = '0;
        header_wc_i        = '0;
        payload_valid_i    = 1'b0;
        payload_i          = '0;
        depack_out_valid_i = 1'b0;
    endtask

    task automatic send_header(input logic [5:0] dt, input logic [15:0] wc);
        header_valid_i = 1'b1;
        header_dt_i    = dt;
        header_wc_i    = wc;
        tick();
        header_valid_i = 1'b0;
    endtask

    task automatic drain(input int n);
        depack_out_valid_i = 1'b1;
        repeat (n) tick();
        depack_out_valid_i = 1'b0;
    endtask

    task automatic wait_line_end(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (line_end_o) found = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (!busy_o) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        reset_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            header_valid_i     = 1'($urandom);
            header_dt_i        = 6'($urandom);
            header_wc_i        = 16'($urandom);
            payload_valid_i    = 1'($urandom);
            payload_i          = {$urandom, $urandom};
            depack_out_valid_i = 1'($urandom);
            expected_pixels_i  = 16'($urandom);
            tick();
            outs = {depack_valid_o, depack_data_o, depack_type_o, frame_start_o, frame_end_o,
                    line_start_o, line_end_o, line_count_o, pixel_count_o, busy_o,
                    err_unsupported_o, err_short_o, err_long_o, err_gap_o, err_overrun_o};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %0h want 0", i, outs);
            end
        end
        idle_inputs();
        expected_pixels_i = 16'd0;
        tick();
        reset_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || depack_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b want 0 0", busy_o, depack_valid_o);
        end
    endtask

    task automatic test_raw10();
        int  v0;
        bit  found;
        logic [63:0] w;
        expected_pixels_i = 16'd32;
        send_header(6'h00, 16'd0);
        checks++;
        if (frame_start_o !== 1'b1 || line_count_o !== 16'd0) begin
            errors++;
            $display("FAIL fs: frame_start=%b line_count=%0d want 1 0", frame_start_o, line_count_o);
        end
        tick();
        v0 = n_valid;
        send_header(6'h2B, 16'd40);
        checks++;
        if (line_start_o !== 1'b1 || depack_type_o !== 3'd3 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL raw10_hdr: ls=%b type=%0d busy=%b want 1 3 1", line_start_o, depack_type_o, busy_o);
        end
        for (int k = 0; k < 5; k++) begin
            w = 64'h1111_0000_0000_0000 * (k + 1) + 64'(k);
            payload_valid_i = 1'b1;
            payload_i       = w;
            tick();
            checks++;
            if (depack_valid_o !== 1'b1 || depack_data_o !== w) begin
                errors++;
                $display("FAIL raw10_word%0d: valid=%b data=%h want 1 %h", k, depack_valid_o, depack_data_o, w);
            end
        end
        payload_valid_i = 1'b0;
        drain(4);
        wait_line_end(found);
        checks++;
        if (!found || pixel_count_o !== 16'd32 || line_count_o !== 16'd1 ||
            err_short_o !== 1'b0 || err_long_o !== 1'b0) begin
            errors++;
            $display("FAIL raw10_end: found=%b pix=%0d lines=%0d short=%b long=%b want 1 32 1 0 0",
                     found, pixel_count_o, line_count_o, err_short_o, err_long_o);
        end
        wait_idle(found);
        checks++;
        if (!found || (n_valid - v0) !== 5 || depack_type_o !== 3'd3) begin
            errors++;
            $display("FAIL raw10_valid_cycles: idle=%b cycles=%0d type=%0d want 1 5 3", found, n_valid - v0, depack_type_o);
        end
    endtask

    task automatic test_raw12_excess();
        int  v0;
        bit  found;
        logic [63:0] w;
        expected_pixels_i = 16'd0;
        v0 = n_valid;
        send_header(6'h2C, 16'd44);
        checks++;
        if (depack_type_o !== 3'd4) begin
            errors++;
            $display("FAIL raw12_type: got %0d want 4", depack_type_o);
        end
        for (int k = 0; k < 8; k++) begin
            w = 64'hA5A5_0000_0000_0000 + 64'(k);
            payload_valid_i = 1'b1;
            payload_i       = w;
            tick();
            checks++;
            if (depack_valid_o !== (k < 6)) begin
                errors++;
                $display("FAIL raw12_word%0d: valid=%b want %b", k, depack_valid_o, (k < 6));
            end
        end
        payload_valid_i = 1'b0;
        drain(4);
        wait_line_end(found);
        checks++;
        if (!found || line_count_o !== 16'd2 || pixel_count_o !== 16'd32) begin
            errors++;
            $display("FAIL raw12_end: found=%b lines=%0d pix=%0d want 1 2 32", found, line_count_o, pixel_count_o);
        end
        wait_idle(found);
        checks++;
        if (!found || (n_valid - v0) !== 6 || low_run < GAP) begin
            errors++;
            $display("FAIL raw12_forwarded: idle=%b words=%0d low_run=%0d want 1 6 >=%0d", found, n_valid - v0, low_run, GAP);
        end
    endtask

    task automatic test_unsupported();
        int  v0, ls0, le0, u0;
        bit  found;
        v0 = n_valid; ls0 = n_ls; le0 = n_le; u0 = n_unsup;
        send_header(6'h2A, 16'd16);
        checks++;
        if (err_unsupported_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL unsup_hdr: err=%b busy=%b want 1 1", err_unsupported_o, busy_o);
        end
        payload_valid_i = 1'b1;
        payload_i       = 64'hDEAD_BEEF_0000_0001;
        tick();
        tick();
        payload_valid_i = 1'b0;
        wait_idle(found);
        checks++;
        if (!found || (n_valid - v0) !== 0 || (n_ls - ls0) !== 0 || (n_le - le0) !== 0 || (n_unsup - u0) !== 1) begin
            errors++;
            $display("FAIL unsup_body: idle=%b valid=%0d ls=%0d le=%0d unsup=%0d want 1 0 0 0 1",
                     found, n_valid - v0, n_ls - ls0, n_le - le0, n_unsup - u0);
        end
        send_header(6'h2B, 16'd0);
        checks++;
        if (busy_o !== 1'b0 || line_start_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_wc0: busy=%b ls=%b want 0 0", busy_o, line_start_o);
        end
    endtask

    task automatic test_errors();
        bit found;
        expected_pixels_i = 16'd32;
        send_header(6'h2B, 16'd40);
        payload_valid_i = 1'b1;
        payload_i       = 64'h0101_0101_0101_0101;
        tick();
        payload_i      = 64'h0202_0202_0202_0202;
        header_valid_i = 1'b1;
        header_dt_i    = 6'h2C;
        header_wc_i    = 16'd8;
        tick();
        header_valid_i = 1'b0;
        checks++;
        if (err_overrun_o !== 1'b1 || depack_type_o !== 3'd3 || depack_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun: err=%b type=%0d valid=%b want 1 3 1", err_overrun_o, depack_type_o, depack_valid_o);
        end
        payload_valid_i = 1'b0;
        tick();
        checks++;
        if (err_gap_o !== 1'b1 || depack_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL gap: err=%b valid=%b want 1 0", err_gap_o, depack_valid_o);
        end
        drain(2);
        wait_line_end(found);
        checks++;
        if (!found || pixel_count_o !== 16'd16 || err_short_o !== 1'b1 || err_long_o !== 1'b0 || line_count_o !== 16'd3) begin
            errors++;
            $display("FAIL short: found=%b pix=%0d short=%b long=%b lines=%0d want 1 16 1 0 3",
                     found, pixel_count_o, err_short_o, err_long_o, line_count_o);
        end
        wait_idle(found);
    endtask

    task automatic test_long();
        bit found;
        expected_pixels_i = 16'd16;
        send_header(6'h2D, 16'd8);
        checks++;
        if (depack_type_o !== 3'd5) begin
            errors++;
            $display("FAIL raw14_type: got %0d want 5", depack_type_o);
        end
        payload_valid_i = 1'b1;
        payload_i       = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        payload_valid_i = 1'b0;
        drain(3);
        wait_line_end(found);
        checks++;
        if (!found || pixel_count_o !== 16'd24 || err_long_o !== 1'b1 || err_short_o !== 1'b0 || line_count_o !== 16'd4) begin
            errors++;
            $display("FAIL long: found=%b pix=%0d long=%b short=%b lines=%0d want 1 24 1 0 4",
                     found, pixel_count_o, err_long_o, err_short_o, line_count_o);
        end
        wait_idle(found);
        send_header(6'h01, 16'd0);
        checks++;
        if (frame_end_o !== 1'b1 || line_count_o !== 16'd4) begin
            errors++;
            $display("FAIL fe: frame_end=%b lines=%0d want 1 4", frame_end_o, line_count_o);
        end
    endtask

    task automatic test_reset_mid();
        int le0;
        expected_pixels_i = 16'd0;
        send_header(6'h2B, 16'd40);
        payload_valid_i = 1'b1;
        payload_i       = 64'h7777_7777_7777_7777;
        tick();
        checks++;
        if (depack_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: valid=%b want 1", depack_valid_o);
        end
        le0 = n_le;
        #1;
        reset_i = 1'b1;
        #1;
        checks++;
        if (depack_valid_o !== 1'b0 || busy_o !== 1'b0 || line_count_o !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b lines=%0d want 0 0 0", depack_valid_o, busy_o, line_count_o);
        end
        tick();
        tick();
        idle_inputs();
        reset_i = 1'b0;
        repeat (4) tick();
        checks++;
        if ((n_le - le0) !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_end: line_ends=%0d busy=%b want 0 0", n_le - le0, busy_o);
        end
    endtask

    initial begin
        idle_inputs();
        expected_pixels_i = 16'd0;
        reset_i = 1'b1;
        test_reset();
        test_raw10();
        test_raw12_excess();
        test_unsupported();
        test_errors();
        test_long();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
